// File: rtl/spi_rom_line_fetch.sv
// SPI flash (mode 0, READ 0x03) line fetcher feeding a double-buffered line store.
// One bank fills from flash while the other is served to the pixel path.
module spi_rom_line_fetch #(
  parameter int LINE_BYTES = 20,
  parameter int RD_AW      = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [23:0]      base_addr_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             spi_cs_n_o,
  output logic             spi_sclk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i,
  input  logic [RD_AW-1:0] rd_addr_i,
  output logic [7:0]       rd_data_o
);

  localparam int              IDX_W    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);
  localparam logic [RD_AW:0]   LINE_LIM = (RD_AW + 1)'(LINE_BYTES);
  localparam logic [7:0]       CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             wbank_q, wbank_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             wr_en_s;
  logic             active_s;
  logic [IDX_W-1:0] rd_idx_s;

  logic [7:0] line_mem_q [0:1][0:LINE_BYTES-1];

  assign rd_idx_s = rd_addr_i[IDX_W-1:0];

  // Bit engine: phase 0 presents MOSI with SCLK low, phase 1 raises SCLK;
  // the edge closing phase 1 samples MISO and advances to the next bit.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    wr_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_CMD;
          phase_d    = 1'b0;
          bit_cnt_d  = 5'd0;
          byte_idx_d = '0;
          tx_d       = {CMD_READ, base_addr_i};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD, ST_ADDR: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          tx_d    = {tx_q[30:0], 1'b0};
          if ((state_q == ST_CMD) && (bit_cnt_q == 5'd7)) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 5'd0;
          end else if ((state_q == ST_ADDR) && (bit_cnt_q == 5'd23)) begin
            state_d   = ST_DATA;
            bit_cnt_d = 5'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          rx_d    = {rx_q[6:0], spi_miso_i};
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            wr_en_s   = 1'b1;
            if (byte_idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              byte_idx_d = byte_idx_q + IDX_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pins are registered copies of the next state, so they switch with the FSM.
  always_comb begin
    active_s = (state_d == ST_CMD) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    cs_n_d   = ~active_s;
    busy_d   = active_s;
    sclk_d   = active_s & phase_d;
    done_d   = (state_d == ST_DONE);
    wbank_d  = (state_q == ST_DONE) ? ~wbank_q : wbank_q;
    if ((state_d == ST_CMD) || (state_d == ST_ADDR)) begin
      mosi_d = tx_d[31];
    end else begin
      mosi_d = 1'b0;
    end
    if ({1'b0, rd_addr_i} < LINE_LIM) begin
      rd_data_d = line_mem_q[~wbank_q][rd_idx_s];
    end else begin
      rd_data_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= 1'b0;
      bit_cnt_q  <= 5'd0;
      byte_idx_q <= '0;
      tx_q       <= 32'd0;
      rx_q       <= 8'd0;
      wbank_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rd_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      wbank_q    <= wbank_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Line store is deliberately unreset; contents are undefined until filled.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      line_mem_q[wbank_q][byte_idx_q] <= rx_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_sclk_o = sclk_q;
  assign spi_mosi_o = mosi_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_spi_rom_line_fetch.sv
// Randomized bench for spi_rom_line_fetch: behavioural flash model plus a
// line-level double-buffer reference for the read port.
module tb_spi_rom_line_fetch;

  localparam int LB        = 20;
  localparam int AW        = 5;
  localparam int CS_LOW    = 64 + 16 * LB;
  localparam int DONE_CYC  = 65 + 16 * LB;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [23:0]   base_addr_i = 24'd0;
  logic          busy_o, done_o, spi_cs_n_o, spi_sclk_o, spi_mosi_o;
  logic          spi_miso_i = 1'b0;
  logic [AW-1:0] rd_addr_i = 5'd25;
  logic [7:0]    rd_data_o;

  spi_rom_line_fetch #(.LINE_BYTES(LB), .RD_AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .busy_o(busy_o), .done_o(done_o), .spi_cs_n_o(spi_cs_n_o), .spi_sclk_o(spi_sclk_o),
    .spi_mosi_o(spi_mosi_o), .spi_miso_i(spi_miso_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Flash model: collects 32 command/address bits, then serves fl_data MSB first.
  logic [7:0]  fl_data [32];
  logic [31:0] fl_cmd;
  int          fl_bits = 0;
  int          fl_mosi_err = 0;

  always @(negedge spi_cs_n_o) begin
    fl_bits     = 0;
    fl_cmd      = 32'd0;
    fl_mosi_err = 0;
  end

  always @(posedge spi_sclk_o) begin
    if (!spi_cs_n_o) begin
      if (fl_bits < 32) begin
        fl_cmd = {fl_cmd[30:0], spi_mosi_o};
      end else begin
        if (spi_mosi_o !== 1'b0) fl_mosi_err++;
        if (fl_bits - 32 < 8 * LB)
          spi_miso_i = fl_data[(fl_bits - 32) / 8][7 - ((fl_bits - 32) % 8)];
      end
      fl_bits++;
    end
  end

  // Line-level reference: whole line lands in the write bank at done, then banks swap.
  logic [7:0] ref_bank [2][32];
  bit         ref_valid [2];
  bit         ref_wbank = 1'b0;
  bit         exp_chk = 1'b0;
  logic [7:0] exp_rd = 8'h00;

  task automatic rd_issue(input int a);
    rd_addr_i = a[AW-1:0];
    if (a >= LB) begin
      exp_chk = 1'b1;
      exp_rd  = 8'h00;
    end else begin
      exp_chk = ref_valid[!ref_wbank];
      exp_rd  = ref_bank[!ref_wbank][a];
    end
  endtask

  task automatic rd_check();
    if (exp_chk) check_eq("rd_data", {24'd0, rd_data_o}, {24'd0, exp_rd});
  endtask

  task automatic load_pattern(input int kind);
    for (int i = 0; i < 32; i++) begin
      case (kind)
        0:       fl_data[i] = 8'hA0 + 8'(i);
        1:       fl_data[i] = 8'h11;
        2:       fl_data[i] = 8'h22;
        default: fl_data[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic run_fetch(input logic [23:0] base, input int abort_at, input bit spam);
    int cs_low = 0, done_cnt = 0, done_at = -1, busy_err = 0;
    bit aborted = 1'b0;
    @(negedge clk_i);
    rd_check();
    start_i     = 1'b1;
    base_addr_i = base;
    rd_issue($urandom_range(0, 31));
    for (int cyc = 1; cyc <= DONE_CYC + 5; cyc++) begin
      @(negedge clk_i);
      rd_check();
      if (!spi_cs_n_o) cs_low++;
      if (busy_o !== !spi_cs_n_o) busy_err++;
      if (done_o) begin
        done_cnt++;
        done_at = cyc;
      end
      if (cyc == 1) begin
        check_eq("first_cs_n", {31'd0, spi_cs_n_o}, 32'd0);
        check_eq("first_busy", {31'd0, busy_o}, 32'd1);
        check_eq("first_mosi", {31'd0, spi_mosi_o}, 32'd0);
        check_eq("first_sclk", {31'd0, spi_sclk_o}, 32'd0);
      end
      if (cyc == abort_at) begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        #1;
        check_eq("abort_cs_n", {31'd0, spi_cs_n_o}, 32'd1);
        check_eq("abort_sclk", {31'd0, spi_sclk_o}, 32'd0);
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_rd", {24'd0, rd_data_o}, 32'd0);
        ref_wbank    = 1'b0;
        ref_valid[0] = 1'b0;
        exp_chk      = 1'b0;
        @(negedge clk_i);
        check_eq("abort_done", {31'd0, done_o}, 32'd0);
        rst_i = 1'b0;
        rd_issue($urandom_range(0, 31));
        aborted = 1'b1;
        break;
      end
      if (spam && cyc < DONE_CYC) start_i = 1'($urandom);
      else if (spam && cyc == DONE_CYC) start_i = 1'b1;
      else start_i = 1'b0;
      rd_issue($urandom_range(0, 31));
      if (done_o) begin
        for (int i = 0; i < LB; i++) ref_bank[ref_wbank][i] = fl_data[i];
        ref_valid[ref_wbank] = 1'b1;
        ref_wbank = !ref_wbank;
      end
    end
    if (aborted) begin
      check_eq("abort_no_done", done_cnt, 0);
    end else begin
      check_eq("cs_low_cycles", cs_low, CS_LOW);
      check_eq("done_count", done_cnt, 1);
      check_eq("done_cycle", done_at, DONE_CYC);
      check_eq("cmd_addr", fl_cmd, {8'h03, base});
      check_eq("sclk_edges", fl_bits, 32 + 8 * LB);
      check_eq("mosi_in_data", fl_mosi_err, 0);
      check_eq("busy_vs_cs", busy_err, 0);
    end
  endtask

  task automatic read_sweep();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk_i);
      rd_check();
      rd_issue(a);
    end
    @(negedge clk_i);
    rd_check();
    exp_chk = 1'b0;
  endtask

  initial begin
    ref_valid[0] = 1'b0;
    ref_valid[1] = 1'b0;
    load_pattern(0);
    repeat (3) @(negedge clk_i);
    check_eq("rst_cs_n", {31'd0, spi_cs_n_o}, 32'd1);
    check_eq("rst_sclk", {31'd0, spi_sclk_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_mosi", {31'd0, spi_mosi_o}, 32'd0);
    check_eq("rst_rd", {24'd0, rd_data_o}, 32'd0);
    rst_i = 1'b0;
    rd_issue(25);
    repeat (4) begin
      @(negedge clk_i);
      rd_check();
      check_eq("idle_cs_n", {31'd0, spi_cs_n_o}, 32'd1);
    end

    run_fetch(24'h123456, -1, 1'b0);
    read_sweep();

    load_pattern(1);
    run_fetch(24'($urandom), -1, 1'b0);
    load_pattern(2);
    run_fetch(24'($urandom), -1, 1'b0);
    read_sweep();

    load_pattern(3);
    run_fetch(24'($urandom), -1, 1'b1);
    read_sweep();

    load_pattern(3);
    run_fetch(24'($urandom), 100, 1'b0);
    repeat (3) begin
      @(negedge clk_i);
      rd_check();
      rd_issue($urandom_range(20, 31));
    end
    load_pattern(3);
    run_fetch(24'($urandom), -1, 1'b0);
    read_sweep();

    for (int n = 0; n < 3; n++) begin
      load_pattern(3);
      run_fetch(24'($urandom), -1, 1'($urandom));
    end
    read_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rom_line_fetch.md
# spi_rom_line_fetch

Fetches one line of pixel bytes from an external SPI flash ROM (mode 0, READ 0x03) into a double-buffered line store, and serves the previously fetched line to the VGA pixel path through a registered read port. Sits upstream of the VGA output logic inside the tt_um_algofoogle_vga_spi_rom design: the video timing logic pulses `start` during horizontal blanking with the next line's ROM address, then reads pixels back during the visible line.

## Interface
- `LINE_BYTES`, 20, bytes fetched per line (1..32)
- `RD_AW`, 5, read-address width; must satisfy 2**RD_AW >= LINE_BYTES
- `clk` in 1: single system clock
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: one-cycle request to fetch a line; honoured only in IDLE
- `base_addr` in 24: ROM byte address of the line; latched on accepted `start`
- `busy` out 1: high while a fetch is in progress (`spi_cs_n` low)
- `done` out 1: one-cycle pulse when a fetch completes and banks swap
- `spi_cs_n` out 1: flash chip select, active low
- `spi_sclk` out 1: SPI clock, clk/2, idles low
- `spi_mosi` out 1: command/address data to flash, MSB first
- `spi_miso` in 1: data from flash
- `rd_addr` in RD_AW: byte index into the display bank
- `rd_data` out 8: byte at `rd_addr`, registered

## Operation
- States: IDLE, CMD (8 bits), ADDR (24 bits), DATA (LINE_BYTES×8 bits), DONE.
- IDLE: `start`=1 latches `base_addr`, loads shift register with {8'h03, base_addr}, enters CMD. `start` in any other state is ignored (not queued).
- Each SPI bit occupies two clk cycles: phase 0 `spi_sclk`=0 with `spi_mosi` holding the bit; phase 1 `spi_sclk`=1. `spi_miso` is sampled on the clk edge ending phase 1. Bits go MSB first.
- CMD→ADDR after 8 bits, ADDR→DATA after 24 bits. `spi_mosi` is 0 during DATA.
- DATA: received bits shift into a byte register MSB first; each completed byte i (0..LINE_BYTES-1) is written to index i of the write bank on the edge its 8th bit is sampled.
- After the last data bit: `spi_cs_n`=1, `spi_sclk`=0, enter DONE. DONE lasts one cycle: `done`=1, write/display banks swap, then IDLE.
- Two banks of LINE_BYTES bytes. Display bank = !write bank. After reset write bank = 0, display bank = 1.
- Read port: `rd_data` <= display_bank[`rd_addr`] every cycle; if `rd_addr` >= LINE_BYTES, `rd_data` <= 0. Reads never stall and are unaffected by an ongoing fetch.
- Buffer contents are not reset; undefined until first fill.

## Timing
- Reset values: `busy`=0, `done`=0, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `rd_data`=0, state IDLE, write bank 0.
- `start` sampled at edge k → from cycle k+1: `spi_cs_n`=0, `busy`=1, `spi_mosi`=0 (bit 7 of 0x03), `spi_sclk`=0.
- Command+address: 64 cycles; data: 16×LINE_BYTES cycles. `spi_cs_n` low for exactly 64+16×LINE_BYTES cycles (384 for default).
- `done` high in cycle k+65+16×LINE_BYTES; `busy` low in that cycle. Earliest next accepted `start` is sampled at the edge ending the DONE cycle+1 (IDLE), so `spi_cs_n` high ≥ 2 cycles between fetches.
- Bank swap takes effect at the edge ending DONE; `rd_data` reflects the new display bank one cycle after that (1-cycle read latency).
- `rst` asserted mid-fetch: outputs go to reset values immediately (asynchronous), no `done`, bank select reset to 0; partially written bank contents undefined.

## Test plan
- Reset then idle: `rst` pulse → `spi_cs_n`=1, `spi_sclk`=0, `busy`=0, `rd_data`=0; `rd_addr`=25 → `rd_data`=0 at any time.
- Command framing: `start` with `base_addr`=24'h12_34_56 → MOSI bits on successive SCLK rising edges = 0x03,0x12,0x34,0x56 MSB first; `spi_cs_n` low exactly 384 cycles; `done` single pulse 385 cycles after `start` edge.
- Data capture: flash model returns bytes 0xA0+i for i=0..19 → after `done`, `rd_addr`=0..19 yields 0xA0..0xB3 with 1-cycle latency.
- Double buffering: fill line with 0x11s, then start second fetch returning 0x22s; during second fetch reads return 0x11; after second `done` reads return 0x22.
- Ignored start: assert `start` repeatedly while `busy`=1 and in DONE cycle → no extra SPI traffic, `spi_cs_n` low duration unchanged, only one `done`.
- Reset mid-fetch: assert `rst` at cycle 100 of a fetch → `spi_cs_n`=1 same cycle, no `done`; new `start` after release produces a full, correct fetch into bank 0.
